// File: rtl/tmu2_csrseq.sv
// tmu2_csrseq: queued CSR write/read/poll/sync sequencer; TMU2_CSRSEQ_TIMEOUT_EN adds a poll timeout and sticky err
module tmu2_csrseq #(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int fifo_depth = 3
`ifdef TMU2_CSRSEQ_TIMEOUT_EN
  , parameter logic [15:0] poll_timeout = 16'hffff
`endif
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_stb,
  output logic        cmd_ack,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_reg,
  input  logic [31:0] cmd_data,
  output logic [13:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_do,
  input  logic [31:0] csr_di,
  output logic [31:0] rdata,
  output logic        rdata_stb,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        err_clr
);
  localparam int aw = fifo_depth;
  typedef enum logic [1:0] {IDLE, WRITE, READ, SAMPLE} state_t;
  state_t state, state_nx;
  logic [38:0] fifo [1<<aw];
  logic [aw-1:0] wp, rp;
  logic [aw:0] cnt;
  logic [1:0] op, head_op;
  logic [4:0] head_reg;
  logic [31:0] mask, head_data;
  logic push, pop, hit, tout;
  assign cmd_ack = ~cnt[aw];
  assign push = cmd_stb & cmd_ack;
  assign pop = (state == IDLE) & (cnt != '0);
  assign busy = (cnt != '0) | (state != IDLE);
  assign {head_op, head_reg, head_data} = fifo[rp];
  assign hit = (csr_di & mask) == 32'd0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !pop ? IDLE : head_op == 2'b00 ? WRITE : head_op == 2'b11 ? IDLE : READ;
      WRITE:   state_nx = IDLE;
      READ:    state_nx = SAMPLE;
      default: state_nx = (op == 2'b01 || hit || tout) ? IDLE : SAMPLE;
    endcase
  end
  always_ff @(posedge sys_clk)
    if (push) fifo[wp] <= {cmd_op, cmd_reg, cmd_data};
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      op <= 2'b00;
      mask <= '0;
      csr_a <= '0;
      csr_we <= 1'b0;
      csr_do <= '0;
      rdata <= '0;
      rdata_stb <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wp <= wp + aw'(1);
      if (pop) rp <= rp + aw'(1);
      cnt <= cnt + {{aw{1'b0}}, push} - {{aw{1'b0}}, pop};
      csr_we <= pop && head_op == 2'b00;
      done <= pop && head_op == 2'b11;
      rdata_stb <= state == SAMPLE && op == 2'b01;
      if (pop) begin
        csr_a <= {csr_addr, 5'b0, head_reg};
        op <= head_op;
        mask <= head_data;
      end
      if (pop && head_op == 2'b00) csr_do <= head_data;
      if (state == SAMPLE && op == 2'b01) rdata <= csr_di;
    end
  end
`ifdef TMU2_CSRSEQ_TIMEOUT_EN
  logic [15:0] tcnt;
  assign tout = state == SAMPLE && op == 2'b10 && !hit && tcnt + 16'd1 == poll_timeout;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tcnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == READ) tcnt <= '0;
      else if (state == SAMPLE && op == 2'b10 && !hit) tcnt <= tcnt + 16'd1;
      err <= tout | (err & ~err_clr);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign tout = 1'b0;
  assign err = 1'b0;
`endif
endmodule
